// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch front-end: ROM line capture, per-slot delivery, redirect (optional FETCH_PERF_CNT_EN counter)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  rom_addr,
    input  logic [127:0] rom_data,
    input  logic         fetch_en,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic [31:0]  instr_count
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;

    // fetch_pc holds byte address bits [31:2]: [31:4] is the next line, [3:2] its start slot
    logic [29:0]    fetch_pc;
    logic [127:0]   line_buf;
    logic [27:0]    line_base;
    logic [1:0]     slot;

    logic           transfer;
    logic           capture;
    logic           advance;
    logic           unused_bits;

    assign transfer    = instr_valid & instr_ready;
    assign rom_addr    = {fetch_pc[29:2], 4'b0000};
    assign instr_valid = (state == DRAIN);
    assign instr       = line_buf[{slot, 5'b00000} +: 32];
    assign instr_pc    = {line_base, slot, 2'b00};
    assign unused_bits = ^redirect_pc[1:0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus line-capture / slot-advance strobes; redirect overrides everything
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            FILL: begin
                if (fetch_en) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (transfer) begin
                    if (slot != 2'd3) begin
                        advance = 1'b1;
                    end else if (fetch_en) begin
                        capture = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
        if (redirect_valid) begin
            state_next = FILL;
            capture    = 1'b0;
            advance    = 1'b0;
        end
    end

    // Line buffer, fetch pointer and slot datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC[31:2];
            line_buf  <= '0;
            line_base <= RESET_PC[31:4];
            slot      <= RESET_PC[3:2];
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc[31:2];
        end else if (capture) begin
            line_buf  <= rom_data;
            line_base <= fetch_pc[29:2];
            slot      <= fetch_pc[1:0];
            fetch_pc  <= {fetch_pc[29:2] + 28'd1, 2'b00};
        end else if (advance) begin
            slot <= slot + 2'd1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    // Delivered-instruction counter, survives redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'h0;
        end else if (transfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'h0;
`endif

endmodule
